// File: rtl/keypad_entry.sv
// keypad_entry: front-panel command assembler between the keyboard scanner
// and cpu_control. Hex digits build a 16-bit entry value, load/dec manage the
// monitor address, and store/register keys issue one write command over a
// valid/ack handshake. Keys are only honoured while the CPU is halted.
// Optional build macro KEYPAD_ENTRY_TIMEOUT_EN adds an ack timeout that
// abandons a stuck command and raises the sticky cmd_err flag.
module keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        CLK25MHZ,
  input  logic        rst_n,
  input  logic        stopped,
  input  logic [15:0] b_hex,
  input  logic        b_load,
  input  logic        b_storeinc,
  input  logic        b_dec,
  input  logic        b_toA,
  input  logic        b_toX,
  input  logic        b_toY,
  input  logic        b_toSP,
  input  logic        b_toPC,
  output logic [15:0] entry,
  output logic [2:0]  digits,
  output logic [15:0] addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_data,
  input  logic        cmd_ack,
  output logic        key_dropped,
  output logic        cmd_err
);

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  localparam logic [2:0] OP_MEM = 3'd0;
  localparam logic [2:0] OP_A   = 3'd1;
  localparam logic [2:0] OP_X   = 3'd2;
  localparam logic [2:0] OP_Y   = 3'd3;
  localparam logic [2:0] OP_SP  = 3'd4;
  localparam logic [2:0] OP_PC  = 3'd5;

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  digits_q, digits_d;
  logic [15:0] addr_q, addr_d;
  logic        cmdValid_q, cmdValid_d;
  logic [2:0]  cmdOp_q, cmdOp_d;
  logic [15:0] cmdAddr_q, cmdAddr_d;
  logic [15:0] cmdData_q, cmdData_d;
  logic        keyDropped_q, keyDropped_d;

  logic [3:0]  hexDigit;
  logic        hexAny;
  logic        cmdKey;
  logic        anyKey;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmdErr_q, cmdErr_d;
`endif

  assign hexAny = |b_hex;
  assign cmdKey = b_storeinc | b_toPC | b_toA | b_toX | b_toY | b_toSP;
  assign anyKey = hexAny | b_load | b_dec | cmdKey;

  // Encode the lowest set bit of the one-hot digit bus (descending scan, last hit wins)
  always_comb begin
    hexDigit = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (b_hex[i]) hexDigit = 4'(i);
    end
  end

  // Next-state and datapath: key decode in IDLE, handshake completion in REQ
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    digits_d     = digits_q;
    addr_d       = addr_q;
    cmdValid_d   = cmdValid_q;
    cmdOp_d      = cmdOp_q;
    cmdAddr_d    = cmdAddr_q;
    cmdData_d    = cmdData_q;
    keyDropped_d = 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    cnt_d        = cnt_q;
    cmdErr_d     = cmdErr_q;
`endif
    case (state_q)
      IDLE: begin
        if (stopped && anyKey) begin
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
          cmdErr_d = 1'b0;
`endif
          if (hexAny) begin
            entry_d  = {entry_q[11:0], hexDigit};
            digits_d = (digits_q == 3'd4) ? 3'd4 : digits_q + 3'd1;
          end else if (b_load) begin
            addr_d   = entry_q;
            entry_d  = 16'h0000;
            digits_d = 3'd0;
          end else if (b_dec) begin
            addr_d = addr_q - 16'h0001;
          end else begin
            state_d    = REQ;
            cmdValid_d = 1'b1;
            cmdAddr_d  = 16'h0000;
            cmdData_d  = {8'h00, entry_q[7:0]};
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
            cnt_d      = '0;
`endif
            if (b_storeinc) begin
              cmdOp_d   = OP_MEM;
              cmdAddr_d = addr_q;
            end else if (b_toPC) begin
              cmdOp_d   = OP_PC;
              cmdData_d = entry_q;
            end else if (b_toA) begin
              cmdOp_d = OP_A;
            end else if (b_toX) begin
              cmdOp_d = OP_X;
            end else if (b_toY) begin
              cmdOp_d = OP_Y;
            end else begin
              cmdOp_d = OP_SP;
            end
          end
        end
      end
      REQ: begin
        if (stopped && anyKey) keyDropped_d = 1'b1;
        if (cmd_ack) begin
          state_d    = IDLE;
          cmdValid_d = 1'b0;
          entry_d    = 16'h0000;
          digits_d   = 3'd0;
          if (cmdOp_q == OP_MEM) addr_d = addr_q + 16'h0001;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          cmdValid_d = 1'b0;
          cmdErr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n
  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      entry_q      <= 16'h0000;
      digits_q     <= 3'd0;
      addr_q       <= 16'h0000;
      cmdValid_q   <= 1'b0;
      cmdOp_q      <= 3'd0;
      cmdAddr_q    <= 16'h0000;
      cmdData_q    <= 16'h0000;
      keyDropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      digits_q     <= digits_d;
      addr_q       <= addr_d;
      cmdValid_q   <= cmdValid_d;
      cmdOp_q      <= cmdOp_d;
      cmdAddr_q    <= cmdAddr_d;
      cmdData_q    <= cmdData_d;
      keyDropped_q <= keyDropped_d;
    end
  end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cmdErr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cmdErr_q <= cmdErr_d;
    end
  end

  assign cmd_err = cmdErr_q;
`else
  assign cmd_err = 1'b0;
`endif

  assign entry       = entry_q;
  assign digits      = digits_q;
  assign addr        = addr_q;
  assign cmd_valid   = cmdValid_q;
  assign cmd_op      = cmdOp_q;
  assign cmd_addr    = cmdAddr_q;
  assign cmd_data    = cmdData_q;
  assign key_dropped = keyDropped_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed self-checking bench for keypad_entry.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_entry;

  localparam logic [7:0] K_LOAD = 8'h01;
  localparam logic [7:0] K_DEC  = 8'h02;
  localparam logic [7:0] K_ST   = 8'h04;
  localparam logic [7:0] K_PC   = 8'h08;
  localparam logic [7:0] K_A    = 8'h10;
  localparam logic [7:0] K_X    = 8'h20;
  localparam logic [7:0] K_Y    = 8'h40;
  localparam logic [7:0] K_SP   = 8'h80;

  logic        CLK25MHZ;
  logic        rst_n;
  logic        stopped;
  logic [15:0] b_hex;
  logic        b_load, b_storeinc, b_dec;
  logic        b_toA, b_toX, b_toY, b_toSP, b_toPC;
  logic [15:0] entry;
  logic [2:0]  digits;
  logic [15:0] addr;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ack;
  logic        key_dropped;
  logic        cmd_err;

  int checks;
  int failures;

  keypad_entry #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .CLK25MHZ   (CLK25MHZ),
    .rst_n      (rst_n),
    .stopped    (stopped),
    .b_hex      (b_hex),
    .b_load     (b_load),
    .b_storeinc (b_storeinc),
    .b_dec      (b_dec),
    .b_toA      (b_toA),
    .b_toX      (b_toX),
    .b_toY      (b_toY),
    .b_toSP     (b_toSP),
    .b_toPC     (b_toPC),
    .entry      (entry),
    .digits     (digits),
    .addr       (addr),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_ack    (cmd_ack),
    .key_dropped(key_dropped),
    .cmd_err    (cmd_err)
  );

  // 25 MHz clock
  initial begin
    CLK25MHZ = 1'b0;
    forever #20 CLK25MHZ = ~CLK25MHZ;
  end

  // Count a comparison and report it if the value differs
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of key pulses, then release them
  task automatic applyStimulus(input logic [15:0] hex, input logic [7:0] keys);
    @(negedge CLK25MHZ);
    b_hex      = hex;
    b_load     = keys[0];
    b_dec      = keys[1];
    b_storeinc = keys[2];
    b_toPC     = keys[3];
    b_toA      = keys[4];
    b_toX      = keys[5];
    b_toY      = keys[6];
    b_toSP     = keys[7];
    @(negedge CLK25MHZ);
    b_hex      = 16'h0000;
    {b_load, b_dec, b_storeinc, b_toPC, b_toA, b_toX, b_toY, b_toSP} = 8'h00;
  endtask

  task automatic pressDigit(input int d);
    applyStimulus(16'h0001 << d, 8'h00);
  endtask

  task automatic pulseAck();
    @(negedge CLK25MHZ);
    cmd_ack = 1'b1;
    @(negedge CLK25MHZ);
    cmd_ack = 1'b0;
  endtask

  task automatic checkCmd(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] d);
    checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    checkOutput({tag, "_op"},    32'(cmd_op),    32'(op));
    checkOutput({tag, "_addr"},  32'(cmd_addr),  32'(a));
    checkOutput({tag, "_data"},  32'(cmd_data),  32'(d));
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    stopped = 1'b0;
    cmd_ack = 1'b0;
    b_hex = 16'h0000;
    {b_load, b_dec, b_storeinc, b_toPC, b_toA, b_toX, b_toY, b_toSP} = 8'h00;
    repeat (2) @(negedge CLK25MHZ);

    // Reset state
    checkOutput("rst_entry", 32'(entry), 32'h0);
    checkOutput("rst_digits", 32'(digits), 32'h0);
    checkOutput("rst_addr", 32'(addr), 32'h0);
    checkOutput("rst_valid", 32'(cmd_valid), 32'h0);
    checkOutput("rst_cmd", {13'h0, cmd_op, cmd_addr}, 32'h0);
    checkOutput("rst_data", 32'(cmd_data), 32'h0);
    checkOutput("rst_flags", {30'h0, key_dropped, cmd_err}, 32'h0);
    rst_n = 1'b1;
    stopped = 1'b1;

    // Digit accumulation, saturation of digit count, load
    pressDigit(1); pressDigit(2); pressDigit(3); pressDigit(4);
    checkOutput("t1_entry4", 32'(entry), 32'h1234);
    checkOutput("t1_digits4", 32'(digits), 32'd4);
    pressDigit(5);
    checkOutput("t1_entry5", 32'(entry), 32'h2345);
    checkOutput("t1_digits5", 32'(digits), 32'd4);
    applyStimulus(16'h0000, K_LOAD);
    checkOutput("t1_load_addr", 32'(addr), 32'h2345);
    checkOutput("t1_load_entry", 32'(entry), 32'h0);
    checkOutput("t1_load_digits", 32'(digits), 32'd0);

    // Store-inc at FFFF wraps address to 0000
    repeat (4) pressDigit(15);
    applyStimulus(16'h0000, K_LOAD);
    checkOutput("t2_addr", 32'(addr), 32'hFFFF);
    pressDigit(3); pressDigit(12);
    applyStimulus(16'h0000, K_ST);
    checkCmd("t2_cmd", 3'd0, 16'hFFFF, 16'h003C);
    repeat (3) @(negedge CLK25MHZ);
    checkCmd("t2_hold", 3'd0, 16'hFFFF, 16'h003C);
    pulseAck();
    checkOutput("t2_ack_valid", 32'(cmd_valid), 32'd0);
    checkOutput("t2_ack_addr", 32'(addr), 32'h0000);
    checkOutput("t2_ack_entry", 32'(entry), 32'h0000);
    pulseAck();
    checkOutput("t2_idle_ack_addr", 32'(addr), 32'h0000);
    checkOutput("t2_idle_ack_valid", 32'(cmd_valid), 32'd0);

    // PC write, busy drop, stopped falling mid-command
    pressDigit(10); pressDigit(11); pressDigit(12); pressDigit(13);
    applyStimulus(16'h0000, K_PC);
    checkCmd("t3_pc", 3'd5, 16'h0000, 16'hABCD);
    pressDigit(7);
    checkOutput("t3_dropped", 32'(key_dropped), 32'd1);
    checkOutput("t3_entry_kept", 32'(entry), 32'hABCD);
    @(negedge CLK25MHZ);
    checkOutput("t3_dropped_end", 32'(key_dropped), 32'd0);
    stopped = 1'b0;
    applyStimulus(16'h0000, K_A);
    checkOutput("t3_stopped0_drop", 32'(key_dropped), 32'd0);
    checkCmd("t3_still_pending", 3'd5, 16'h0000, 16'hABCD);
    stopped = 1'b1;
    pulseAck();
    checkOutput("t3_ack_entry", 32'(entry), 32'h0000);
    checkOutput("t3_ack_addr", 32'(addr), 32'h0000);
    checkOutput("t3_ack_valid", 32'(cmd_valid), 32'd0);

    // Register ops take only the low byte; command key priority
    pressDigit(1); pressDigit(2); pressDigit(15); pressDigit(5);
    applyStimulus(16'h0000, K_A);
    checkCmd("t3_a", 3'd1, 16'h0000, 16'h00F5);
    pulseAck();
    pressDigit(4); pressDigit(2);
    applyStimulus(16'h0000, K_X | K_Y | K_SP);
    checkCmd("t3_x_prio", 3'd2, 16'h0000, 16'h0042);
    pulseAck();
    pressDigit(9);
    applyStimulus(16'h0000, K_SP);
    checkCmd("t3_sp", 3'd4, 16'h0000, 16'h0009);
    pulseAck();
    pressDigit(7);
    applyStimulus(16'h0000, K_ST | K_PC);
    checkCmd("t3_st_prio", 3'd0, 16'h0000, 16'h0007);
    pulseAck();
    checkOutput("t3_st_addr", 32'(addr), 32'h0001);

    // Hex beats command key, lowest bit wins, stopped=0 ignores keys
    applyStimulus(16'h0002, K_A);
    checkOutput("t4_hex_prio_entry", 32'(entry), 32'h0001);
    checkOutput("t4_hex_prio_valid", 32'(cmd_valid), 32'd0);
    applyStimulus(16'h0028, 8'h00);
    checkOutput("t4_multihot", 32'(entry), 32'h0013);
    checkOutput("t4_multihot_digits", 32'(digits), 32'd2);
    stopped = 1'b0;
    pressDigit(9);
    checkOutput("t4_stopped_entry", 32'(entry), 32'h0013);
    checkOutput("t4_stopped_drop", 32'(key_dropped), 32'd0);
    stopped = 1'b1;
    applyStimulus(16'h0000, K_LOAD | K_DEC);
    checkOutput("t4_load_prio", 32'(addr), 32'h0013);
    applyStimulus(16'h0000, K_DEC);
    checkOutput("t4_dec", 32'(addr), 32'h0012);

    // Decrement wrap, async reset mid-command
    applyStimulus(16'h0000, K_LOAD);
    checkOutput("t5_addr0", 32'(addr), 32'h0000);
    applyStimulus(16'h0000, K_DEC);
    checkOutput("t5_dec_wrap", 32'(addr), 32'hFFFF);
    pressDigit(5);
    applyStimulus(16'h0000, K_Y);
    checkCmd("t5_y", 3'd3, 16'h0000, 16'h0005);
    #5 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", 32'(cmd_valid), 32'd0);
    checkOutput("t5_async_addr", 32'(addr), 32'h0000);
    checkOutput("t5_async_entry", 32'(entry), 32'h0000);
    @(negedge CLK25MHZ);
    rst_n = 1'b1;
    pressDigit(6);
    checkOutput("t5_after_rst", 32'(entry), 32'h0006);

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    // Timeout after 8 REQ cycles, error cleared by next key, ack on terminal count wins
    applyStimulus(16'h0000, K_X);
    n = 1;
    while (cmd_valid && n < 50) begin
      @(negedge CLK25MHZ);
      if (cmd_valid) n++;
    end
    checkOutput("t6_timeout_cycles", 32'(n), 32'd8);
    checkOutput("t6_valid_dropped", 32'(cmd_valid), 32'd0);
    checkOutput("t6_err", 32'(cmd_err), 32'd1);
    checkOutput("t6_entry_kept", 32'(entry), 32'h0006);
    pressDigit(2);
    checkOutput("t6_err_clear", 32'(cmd_err), 32'd0);
    checkOutput("t6_entry", 32'(entry), 32'h0062);
    applyStimulus(16'h0000, K_X);
    repeat (6) @(negedge CLK25MHZ);
    checkOutput("t6_valid_before_ack", 32'(cmd_valid), 32'd1);
    pulseAck();
    checkOutput("t6_ack_valid", 32'(cmd_valid), 32'd0);
    checkOutput("t6_ack_err", 32'(cmd_err), 32'd0);
    checkOutput("t6_ack_entry", 32'(entry), 32'h0000);
`else
    // Without the timeout a command waits indefinitely
    applyStimulus(16'h0000, K_X);
    n = 0;
    repeat (20) begin
      @(negedge CLK25MHZ);
      if (cmd_valid) n++;
    end
    checkOutput("t6_no_timeout", 32'(n), 32'd20);
    checkOutput("t6_no_err", 32'(cmd_err), 32'd0);
    pulseAck();
    checkOutput("t6_ack_valid", 32'(cmd_valid), 32'd0);
    checkOutput("t6_ack_entry", 32'(entry), 32'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Front-panel command assembler that sits directly downstream of the keyboard scanner and upstream of cpu_control.
- Consumes one-cycle key pulses: hex digits and the load, store-inc, dec and to-register keys.
- Accumulates hex digits into a 16-bit entry value and maintains a monitor address.
- Issues single-beat write commands to the CPU control block over a valid/ack handshake.
- Key input is accepted only while the CPU is halted.

Parameters:
TIMEOUT_CYCLES, 1024, cycles to wait for cmd_ack before aborting (used only with the optional feature)
CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
CLK25MHZ  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
stopped  input  1  CPU halted; keys are ignored while 0
b_hex  input  16  one-hot digit pulses; bit n = key n (b_0..b_f)
b_load  input  1  pulse: copy entry to addr
b_storeinc  input  1  pulse: write entry[7:0] to memory at addr, then addr+1
b_dec  input  1  pulse: addr-1
b_toA, b_toX, b_toY, b_toSP, b_toPC  input  1 each  pulse: write entry to that register
entry  output  16  digit accumulator, for display
digits  output  3  count of digits entered, saturates at 4
addr  output  16  monitor address
cmd_valid  output  1  command pending
cmd_op  output  3  0=MEM 1=A 2=X 3=Y 4=SP 5=PC
cmd_addr  output  16  memory address (MEM only, else 0)
cmd_data  output  16  payload; [15:8]=0 except PC
cmd_ack  input  1  one-cycle accept from cpu_control
key_dropped  output  1  one-cycle pulse: key lost while busy
cmd_err  output  1  sticky timeout flag; cleared by the next accepted key

Behaviour:
- Reset values: entry=0000, digits=0, addr=0000, cmd_valid=0, cmd_op=0, cmd_addr=0, cmd_data=0, key_dropped=0, cmd_err=0, FSM=IDLE.
- Key qualification: a key is accepted only in IDLE with stopped=1. With stopped=0, all keys are silently ignored; no key_dropped.
- Same-cycle priority: hex digit > b_load > b_dec > b_storeinc > b_toPC > b_toA > b_toX > b_toY > b_toSP. Lower-priority keys in that cycle are discarded.
- Multi-hot b_hex: the lowest set bit wins.
- Hex digit d: entry <= {entry[11:0], d}; digits <= min(digits+1, 4). No FSM change. The 5th and later digits keep shifting.
- b_load: addr <= entry; entry <= 0; digits <= 0. One cycle, no command issued.
- b_dec: addr <= addr-1, mod 2^16 (0000 -> FFFF). entry is unchanged.
- Command keys:
  - Capture cmd_op/cmd_addr/cmd_data from entry/addr; cmd_valid=1 on the next cycle. FSM IDLE -> REQ.
  - b_storeinc: cmd_op=MEM, cmd_addr=addr, cmd_data={8'h00, entry[7:0]}.
  - Register ops: cmd_data={8'h00, entry[7:0]}, except PC, which takes entry[15:0].
- REQ:
  - cmd_valid and all cmd_* fields are held stable until a cycle with cmd_ack=1.
  - On ack: cmd_valid <= 0 in the same clock edge; entry <= 0; digits <= 0. If MEM, addr <= addr+1, mod 2^16 (FFFF -> 0000).
  - Transition REQ -> IDLE. Minimum command latency is key -> valid 1 cycle, ack -> IDLE 1 cycle.
- Busy drop: any key pulse while in REQ is discarded and pulses key_dropped for 1 cycle. Digits are also dropped.
- cmd_ack while in IDLE: ignored.
- stopped falling while in REQ: the command stays pending. It is not cancelled; cpu_control owns its completion.
- rst_n asserted mid-REQ: everything returns to reset values immediately (async); the pending command is lost.

Optional Feature:
Macro: KEYPAD_ENTRY_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter runs in REQ, cleared on entry to REQ.
  - If it reaches TIMEOUT_CYCLES-1 without ack: cmd_valid <= 0, FSM -> IDLE, cmd_err <= 1. entry/digits/addr are unchanged.
  - An ack in the same cycle as the terminal count wins: normal completion, no error.
- Not defined: no counter is built; REQ waits indefinitely; cmd_err is tied 0.

Test Plan:
1. stopped=1; keys 1,2,3,4,5 -> entry=2345, digits=4; then b_load -> addr=2345, entry=0000, digits=0.
2. addr=FFFF; enter 3,C; b_storeinc -> cmd_valid=1 next cycle, op=0, cmd_addr=FFFF, cmd_data=003C; ack 5 cycles later -> cmd_valid=0, addr=0000, entry=0000.
3. Enter A,B,C,D; b_toPC -> op=5, data=ABCD. While pending, press 7 -> key_dropped 1 cycle, entry still ABCD. Ack -> entry=0000.
4. Same cycle b_hex=0x0002 and b_toA -> entry gets digit 1, no command. With stopped=0, press 9 -> entry unchanged, key_dropped=0.
5. addr=0000, b_dec -> FFFF. Assert rst_n=0 mid-REQ -> cmd_valid=0, addr=0000 asynchronously.
6. With KEYPAD_ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=8: b_toX, no ack -> cmd_valid drops after 8 REQ cycles, cmd_err=1. Next digit key -> cmd_err=0. Repeat with ack on cycle 8 -> no error.
